// File: rtl/key_cond_pkg.sv
// Shared types and encodings for the up/down key conditioner.
package key_cond_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    REPEAT  = 2'd2,
    LOCKOUT = 2'd3
  } key_state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchroniser followed by a stable-count debouncer for one key.
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    // Any return to the debounced level restarts the stability count.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign level = level_q;

endmodule

// File: rtl/updown_key_conditioner.sv
// Turns debounced UP/DOWN keys into single-cycle step pulses with hold-to-repeat
// and a lockout that keeps both directions from ever firing together.
module updown_key_conditioner
  import key_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic key_up_raw,
  input  logic key_down_raw,
  output logic up,
  output logic down,
  output logic key_busy
);

  localparam int unsigned TW = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

  logic du, dd;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_deb (
    .clk   (clk),
    .reset (reset),
    .raw   (key_up_raw),
    .level (du)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn_deb (
    .clk   (clk),
    .reset (reset),
    .raw   (key_down_raw),
    .level (dd)
  );

  key_state_t    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          dir_q, dir_d;
  logic          up_q, up_d;
  logic          down_q, down_d;
  logic          busy_q, busy_d;
  logic          fire;
  logic          dir_held;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      dir_q   <= DIR_UP;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      dir_q   <= dir_d;
      up_q    <= up_d;
      down_q  <= down_d;
      busy_q  <= busy_d;
    end
  end

  assign dir_held = (dir_q == DIR_UP) ? du : dd;

  // Abort checks come before the timer so a release or conflict on a
  // terminal-count edge suppresses the pulse.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dir_d   = dir_q;
    fire    = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (du && dd) begin
          state_d = LOCKOUT;
        end else if (du || dd) begin
          fire    = 1'b1;
          dir_d   = du ? DIR_UP : DIR_DOWN;
          state_d = DELAY;
        end
      end
      DELAY, REPEAT: begin
        if (du && dd) begin
          state_d = LOCKOUT;
          timer_d = '0;
        end else if (!dir_held) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (REPEAT_EN) begin
          if (timer_q == ((state_q == DELAY) ? DELAY_LAST : PERIOD_LAST)) begin
            fire    = 1'b1;
            timer_d = '0;
            state_d = REPEAT;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      LOCKOUT: begin
        timer_d = '0;
        if (!du && !dd) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_comb begin
    up_d   = fire && (dir_d == DIR_UP);
    down_d = fire && (dir_d == DIR_DOWN);
    busy_d = (state_d != IDLE);
  end

  assign up       = up_q;
  assign down     = down_q;
  assign key_busy = busy_q;

endmodule
